cp0: RTL and testbench
======================

Name: cp0

Overview:
Coprocessor-0 interrupt/exception controller for the P7 CPU. It is the receiving end of the peripheral interrupt lines: it consumes the level-sensitive IRQs from the timers and the interrupt generator, decides whether to take an interrupt or exception, and saves the return PC. It also holds the SR/Cause/EPC/PRId registers for mfc0/mtc0 and clears EXL on eret. It sits beside the M stage, which is the macro-op commit point.

Parameters:
PRID, 32'h0024_0701, constant value returned when register 15 (PRId) is read.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
A1  input  5  read register number (mfc0)
A2  input  5  write register number (mtc0)
Din  input  32  mtc0 write data
WE  input  1  mtc0 write enable (from M stage)
PC  input  32  PC of the instruction currently in M
BDIn  input  1  the M instruction is in a branch delay slot
ExcCodeIn  input  5  synchronous exception code from M; 0 means none
HWInt  input  6  external interrupt levels; bit0 = Timer0, bit1 = Timer1, bit2 = interrupt generator, bits 3-5 reserved
EXLClr  input  1  eret in M: clear EXL
Req  output  1  take interrupt/exception now (flush the pipeline, redirect to 32'h0000_4180)
EPCOut  output  32  current EPC (eret target)
DOut  output  32  read data for A1

Behaviour:
Register fields:
- SR (12): IM = bits 15:10, EXL = bit 1, IE = bit 0. All other bits read 0.
- Cause (13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2. All other bits read 0.
- EPC (14): full 32 bits, with bits 1:0 always 0.
- PRId (15): returns PRID.
- Any other A1 value reads 32'h0.

Reset:
- SR, Cause and EPC are all 0.
- Req = 0, EPCOut = 0, DOut = per A1.

Req (combinational, same cycle):
- IntReq = |(HWInt & IM) & IE & ~EXL
- ExcReq = (ExcCodeIn != 0) & ~EXL
- Req = IntReq | ExcReq
- When EXL = 1, Req is 0 regardless of any other input.

IP update:
- Cause.IP <= HWInt on every non-reset clock edge, whatever the other inputs are.
- The IRQ source clears its level itself; cp0 never acknowledges it.

On a posedge with Req = 1:
- EXL <= 1.
- BD <= BDIn.
- EPC <= BDIn ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- ExcCode <= IntReq ? 5'd0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.
- Any WE in the same cycle is discarded. The faulting instruction does not commit.

mtc0 (WE = 1, Req = 0):
- A2 = 12: IM <= Din[15:10], EXL <= Din[1], IE <= Din[0].
- A2 = 14: EPC <= {Din[31:2],2'b00}.
- A2 = 13, 15 or other: no effect. Cause and PRId are read-only to software.

EXLClr:
- EXL <= 0 at the next posedge.
- If WE to SR happens in the same cycle, the write sets IM and IE, and EXLClr overrides the EXL bit to 0.
- Req and EXLClr cannot both be 1 in one cycle, because EXLClr implies EXL = 1 and therefore Req = 0.

Read path:
- DOut and EPCOut are combinational from the current register contents.
- No write-through: a read in the same cycle as a write to the same register returns the old value.

Reset mid-operation overrides everything: all registers return to 0 at that edge.

Test Plan:
1. Reset, then read A1 = 12, 13, 14, 15 -> DOut = 0, 0, 0, PRID. Req = 0.
2. mtc0 SR = 32'h0000_0401 (IM0, IE), then HWInt = 6'b000001 with PC = 32'h0000_3010, BDIn = 0 -> Req = 1 in the same cycle. Next cycle: EPC = 32'h0000_3010, Cause = 32'h0000_0400 (ExcCode 0), EXL = 1, Req = 0 while HWInt stays high.
3. EXL = 0, IE = 0, ExcCodeIn = 5'd10 (RI), PC = 32'h0000_3020, BDIn = 1 -> Req = 1. Next cycle: EPC = 32'h0000_301C, Cause = 32'h8000_0028.
4. Same cycle: HWInt enabled interrupt and ExcCodeIn = 5'd4, plus WE to EPC with Din = 32'h1234_5678 -> ExcCode = 0 and EPC = PC; the write is ignored.
5. EXL = 1 and EXLClr = 1 together with mtc0 SR Din = 32'h0000_FC03 -> SR = 32'h0000_FC01. A pending enabled HWInt raises Req on the following cycle.
6. mtc0 EPC Din = 32'h0000_3007 -> EPCOut = 32'h0000_3004. mtc0 to Cause with Din = 32'hFFFF_FFFF -> Cause changes only via IP tracking HWInt.

Source files
------------

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers, interrupt/exception request and EPC capture.
// Sits beside the M stage; Req is combinational so the pipeline can flush in the same cycle.
module cp0 #(
    parameter logic [31:0] PRID = 32'h0024_0701
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_al;

    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    assign Req     = int_req | exc_req;
    assign pc_al   = PC & ~32'h3;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (Req) begin
            // Taking the trap discards any mtc0 of the faulting instruction.
            exl_d      = 1'b1;
            bd_d       = BDIn;
            epc_d      = BDIn ? pc_al - 32'd4 : pc_al;
            exc_code_d = int_req ? 5'd0 : ExcCodeIn;
        end else begin
            if (WE) begin
                if (A2 == 5'd12) begin
                    im_d  = Din[15:10];
                    exl_d = Din[1];
                    ie_d  = Din[0];
                end else if (A2 == 5'd14) begin
                    epc_d = Din & ~32'h3;
                end
            end
            // eret wins over a simultaneous SR write for the EXL bit only.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    assign EPCOut = epc_q;

    always_comb begin
        DOut = 32'h0;
        case (A1)
            5'd12:   DOut = {16'h0, im_q, 8'h0, exl_q, ie_q};
            5'd13:   DOut = {bd_q, 15'h0, ip_q, 3'h0, exc_code_q, 2'h0};
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID;
            default: DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: stimulus pushes expected {Req, DOut, EPCOut} per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h0024_0701;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    cp0 #(.PRID(PRID)) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .Din       (Din),
        .WE        (WE),
        .PC        (PC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .Req       (Req),
        .EPCOut    (EPCOut),
        .DOut      (DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
        int          step;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   step_no = 0;

    // Architectural model: whole 32-bit register words, updated by the ISA-level rules.
    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                        input logic we, input logic [31:0] pc, input logic bd,
                        input logic [4:0] exc, input logic [5:0] hw, input logic clr,
                        input logic rst);
        logic int_take, exc_take, take;
        logic [31:0] pc_w;
        exp_t e;
        A1 = a1; A2 = a2; Din = din; WE = we; PC = pc; BDIn = bd;
        ExcCodeIn = exc; HWInt = hw; EXLClr = clr; reset = rst;

        int_take = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        exc_take = (exc != 5'd0) && !m_sr[1];
        take     = int_take || exc_take;
        e.req = take; e.dout = m_read(a1); e.epc = m_epc; e.step = step_no;
        sb_q.push_back(e);
        step_no++;

        @(posedge clk);
        if (rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            m_cause[15:10] = hw;
            if (take) begin
                pc_w = {pc[31:2], 2'b00};
                m_sr[1]       = 1'b1;
                m_cause[31]   = bd;
                m_epc         = bd ? pc_w - 32'd4 : pc_w;
                m_cause[6:2]  = int_take ? 5'd0 : exc;
            end else begin
                if (we && a2 == 5'd12) m_sr = din & 32'h0000_FC03;
                if (we && a2 == 5'd14) m_epc = {din[31:2], 2'b00};
                if (clr) m_sr[1] = 1'b0;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (Req === e.req && DOut === e.dout && EPCOut === e.epc) begin
                passed++;
            end else begin
                $display("FAIL step%0d: got Req=%b DOut=%h EPCOut=%h, expected Req=%b DOut=%h EPCOut=%h",
                         e.step, Req, DOut, EPCOut, e.req, e.dout, e.epc);
            end
        end
    end

    initial begin
        logic [4:0] ra1, ra2, rexc;
        logic       rclr;
        reset = 1'b1; A1 = 0; A2 = 0; Din = 0; WE = 0; PC = 0; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values and PRId
        for (int i = 12; i <= 16; i++) step(5'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Enabled interrupt, EXL masks further requests
        step(12, 12, 32'h0000_0401, 1, 0, 0, 0, 0, 0, 0);
        step(12, 0, 0, 0, 32'h0000_3010, 0, 0, 6'b000001, 0, 0);
        step(14, 0, 0, 0, 32'h0000_3014, 0, 0, 6'b000001, 0, 0);
        step(13, 0, 0, 0, 32'h0000_3018, 0, 0, 6'b000001, 0, 0);
        step(12, 0, 0, 0, 32'h0000_3018, 0, 5'd9, 6'b000001, 0, 0);
        // Exception in delay slot
        step(12, 12, 32'h0000_0400, 1, 0, 0, 0, 0, 0, 0);
        step(13, 0, 0, 0, 32'h0000_3020, 1, 5'd10, 0, 0, 0);
        step(14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Interrupt beats exception; EPC write discarded
        step(12, 12, 32'h0000_0401, 1, 0, 0, 0, 0, 1, 0);
        step(13, 14, 32'h1234_5678, 1, 32'h0000_3040, 0, 5'd4, 6'b000001, 0, 0);
        step(13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // eret with simultaneous SR write, pending interrupt fires next cycle
        step(12, 12, 32'h0000_FC03, 1, 0, 0, 0, 6'b000100, 1, 0);
        step(12, 0, 0, 0, 32'h0000_3050, 0, 0, 6'b000100, 0, 0);
        step(13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // EPC alignment and read-only Cause
        step(14, 14, 32'h0000_3007, 1, 0, 0, 0, 0, 0, 0);
        step(13, 13, 32'hFFFF_FFFF, 1, 0, 0, 0, 6'b101010, 0, 0);
        step(13, 15, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0);
        step(15, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Mid-operation reset
        step(12, 0, 0, 0, 0, 0, 0, 6'b111111, 0, 1);
        step(13, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ra1  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            ra2  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            rexc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            rclr = m_sr[1] && ($urandom_range(0, 2) == 0);
            step(ra1, ra2, $urandom, ($urandom_range(0, 1) == 1), $urandom,
                 ($urandom_range(0, 3) == 0), rexc, 6'($urandom),
                 rclr, ($urandom_range(0, 60) == 0));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
